sw_debounce_sync: RTL

//   Input conditioner sitting directly upstream of the 4-bit adder / LED display path.

---
 rtl/sw_debounce_sync.sv | 97 +++++++++
 1 files changed

// File: rtl/sw_debounce_sync.sv
// -----------------------------------------------------------------------------
// sw_debounce_sync
//   Conditions the raw board slide switches before they reach the 4-bit adder
//   and LED display path. Each switch bit is synchronised into the clk domain
//   by a two-flop chain. It is then debounced on its own, and only settled
//   levels are presented on sw_stable. Registered edge pulses tell downstream
//   logic when a settled level has changed.
//
// Ports
//   clk         in   1      system clock, all state on the rising edge
//   reset       in   1      asynchronous, active-high; clears all state at once
//   sw_raw      in   WIDTH  raw switch levels, asynchronous to clk, may bounce
//   sw_stable   out  WIDTH  debounced levels ([3:0] -> adder a, [7:4] -> adder b)
//   sw_rise     out  WIDTH  1-cycle pulse per bit whose sw_stable went 0->1
//   sw_fall     out  WIDTH  1-cycle pulse per bit whose sw_stable went 1->0
//   sw_changed  out  1      1-cycle pulse, OR of all rise/fall bits that cycle
//
// Parameters
//   WIDTH            number of switch bits conditioned
//   DEBOUNCE_CYCLES  consecutive cycles a new level must hold (>= 2)
//   CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES-1
// -----------------------------------------------------------------------------
module sw_debounce_sync #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  // Terminal count. A mismatch seen while the counter holds this value is the
  // DEBOUNCE_CYCLES-th consecutive mismatch, so the bit flips on that edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] at_last;
  logic [WIDTH-1:0] flip;

  // Per-bit decode of the current state. Only sync2 feeds the logic, so sw_raw
  // has no combinational path to any output.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    at_last = '0;
    for (int i = 0; i < WIDTH; i++) begin
      at_last[i] = (cnt[i] == CNT_LAST);
    end
    mismatch = sync2 ^ sw_stable;
    flip     = mismatch & at_last;
  end

  // NOTE: sequential state uses non-blocking assignments only, so each register reads pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      sw_stable  <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
      // NOTE: the counter array is ordinary flops and not a RAM, so it is reset like any other state.
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;

      // A match, a bounce back, or a completed flip restarts the count.
      // For this reason the counter never runs past CNT_LAST.
      for (int i = 0; i < WIDTH; i++) begin
        if (!mismatch[i] || at_last[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end

      // A flipping bit takes the sync2 level. The pulses are rebuilt on every
      // edge, so each one lasts exactly one cycle.
      sw_stable  <= sw_stable ^ flip;
      sw_rise    <= flip & sync2;
      sw_fall    <= flip & ~sync2;
      sw_changed <= |flip;
    end
  end

endmodule
